// File: rtl/iir_fixpt_pkg.sv
// Shared fixed-point helpers for the IIR datapath (adder nodes and
// requantizers).
//   - Default word/fraction widths of the internal accumulator format and
//     the external sample format.
//   - fx_round_shr : right shift with round-to-nearest, ties toward +inf.
//   - fx_sat_narrow: clamp a value to a signed out_w-bit range and flag
//     whether clamping happened.
// Both helpers work on a FX_W-bit signed container. Callers sign-extend into
// it and slice the result back out.
package iir_fixpt_pkg;

  localparam int unsigned IIR_ACC_W    = 36;
  localparam int unsigned IIR_ACC_FRAC = 27;
  localparam int unsigned IIR_SMP_W    = 16;
  localparam int unsigned IIR_SMP_FRAC = 14;
  localparam int unsigned IIR_CNT_W    = 16;
  localparam int unsigned FX_W         = 64;

  typedef logic signed [FX_W-1:0] fx_t;

  typedef struct packed {
    logic sat;
    fx_t  val;
  } sat_res_t;

  // Shifts right by sh-1 first. The LSB that remains is the rounding bit
  // (weight 0.5 output LSB), and one more shift gives the floor.
  function automatic fx_t fx_round_shr(input fx_t x, input int unsigned sh);
    fx_t h;
    h = x >>> (sh - 1);
    return (h >>> 1) + fx_t'({{(FX_W-1){1'b0}}, h[0]});
  endfunction

  function automatic sat_res_t fx_sat_narrow(input fx_t r, input int unsigned out_w);
    fx_t      hi;
    fx_t      lo;
    sat_res_t res;
    hi = (fx_t'(1) <<< (out_w - 1)) - fx_t'(1);
    lo = ~hi;
    if (r > hi) begin
      res.sat = 1'b1;
      res.val = hi;
    end else if (r < lo) begin
      res.sat = 1'b1;
      res.val = lo;
    end else begin
      res.sat = 1'b0;
      res.val = r;
    end
    return res;
  endfunction

endpackage

// File: rtl/iir_sat_counter.sv
// Saturating event counter with a sticky flag.
//   clk, reset : clock, async active-high reset
//   i_enb      : clock enable; all state holds when low
//   i_clr      : synchronous clear of count and sticky; wins over i_inc
//   i_inc      : count one event; the count stops at all-ones
//   o_count    : event count
//   o_sticky   : set by the first event, held until cleared
module iir_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_enb,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count,
  output logic             o_sticky
);

  logic [CNT_W-1:0] r_count;
  logic             r_sticky;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count  <= '0;
      r_sticky <= 1'b0;
    end else if (i_enb) begin
      if (i_clr) begin
        r_count  <= '0;
        r_sticky <= 1'b0;
      end else if (i_inc) begin
        if (r_count != '1) r_count <= r_count + CNT_W'(1);
        r_sticky <= 1'b1;
      end
    end
  end

  assign o_count  = r_count;
  assign o_sticky = r_sticky;

endmodule

// File: rtl/iir_out_requant.sv
// Output requantizer: narrows the wide accumulator word (sfixIN_W_EnIN_FRAC)
// to the external sample format (sfixOUT_W_EnOUT_FRAC). It rounds to
// nearest with ties toward +inf, then saturates. The datapath is a 2-stage
// valid/ready pipeline with a saturation counter and a sticky flag.
//   clk, reset          : clock, async active-high reset
//   enb                 : clock enable; freezes state and handshakes
//   in_data/in_valid/in_ready    : input stream
//   out_data/out_valid/out_ready : output stream
//   out_sat             : delivered sample was clamped
//   sat_count/sat_sticky: saturated deliveries; sat_clr clears both
module iir_out_requant
  import iir_fixpt_pkg::*;
#(
  parameter int IN_W     = IIR_ACC_W,
  parameter int IN_FRAC  = IIR_ACC_FRAC,
  parameter int OUT_W    = IIR_SMP_W,
  parameter int OUT_FRAC = IIR_SMP_FRAC,
  parameter int CNT_W    = IIR_CNT_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enb,
  input  logic signed [IN_W-1:0]  in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_sat,
  output logic [CNT_W-1:0]        sat_count,
  output logic                    sat_sticky,
  input  logic                    sat_clr
);

  localparam int SH = IN_FRAC - OUT_FRAC;
  // One bit wider than the shifted input, so the rounding carry cannot wrap.
  localparam int RW = IN_W + 1 - SH;

  if (SH < 1) begin : g_bad_shift
    $fatal(1, "iir_out_requant: IN_FRAC must exceed OUT_FRAC");
  end
  if ((IN_W - IN_FRAC) < (OUT_W - OUT_FRAC)) begin : g_bad_int
    $fatal(1, "iir_out_requant: input integer bits narrower than output");
  end
  if (IN_W >= int'(FX_W)) begin : g_bad_width
    $fatal(1, "iir_out_requant: IN_W exceeds helper container width");
  end

  fx_t      w_in_ext;
  fx_t      w_round;
  fx_t      w_s1_ext;
  sat_res_t w_sat;
  logic     w_adv1;
  logic     w_adv2;
  logic     w_out_xfer;
  // Upper container bits are only sign copies at this point.
  logic [FX_W-RW-1:0]    w_unused_rnd_hi;
  logic [FX_W-OUT_W-1:0] w_unused_sat_hi;

  logic                    r_s1_valid;
  logic signed [RW-1:0]    r_s1_data;
  logic                    r_s2_valid;
  logic signed [OUT_W-1:0] r_out_data;
  logic                    r_out_sat;

  always_comb begin
    w_in_ext        = {{(FX_W-IN_W){in_data[IN_W-1]}}, in_data};
    w_round         = fx_round_shr(w_in_ext, SH);
    w_unused_rnd_hi = w_round[FX_W-1:RW];
    w_s1_ext        = {{(FX_W-RW){r_s1_data[RW-1]}}, r_s1_data};
    w_sat           = fx_sat_narrow(w_s1_ext, OUT_W);
    w_unused_sat_hi = w_sat.val[FX_W-1:OUT_W];
  end

  assign w_adv2     = !r_s2_valid || out_ready;
  assign w_adv1     = !r_s1_valid || w_adv2;
  assign in_ready   = w_adv1 && enb;
  assign w_out_xfer = enb && r_s2_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s2_valid <= 1'b0;
      r_out_data <= '0;
      r_out_sat  <= 1'b0;
    end else if (enb) begin
      if (w_adv1) begin
        r_s1_valid <= in_valid;
        if (in_valid) r_s1_data <= w_round[RW-1:0];
      end
      if (w_adv2) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_out_data <= w_sat.val[OUT_W-1:0];
          r_out_sat  <= w_sat.sat;
        end
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_s2_valid;
  assign out_sat   = r_out_sat;

  iir_sat_counter #(
    .CNT_W(CNT_W)
  ) u_sat_counter (
    .clk      (clk),
    .reset    (reset),
    .i_enb    (enb),
    .i_clr    (sat_clr),
    .i_inc    (w_out_xfer && r_out_sat),
    .o_count  (sat_count),
    .o_sticky (sat_sticky)
  );

endmodule

// File: tb/tb_iir_out_requant.sv
module tb_iir_out_requant;

  logic               clk = 1'b0;
  logic               reset, enb, in_valid, out_ready, sat_clr;
  logic signed [35:0] in_data;
  logic               in_ready, out_valid, out_sat, sat_sticky;
  logic [15:0]        out_data, sat_count;
  logic               in_ready4, out_valid4, out_sat4, sat_sticky4;
  logic [15:0]        out_data4;
  logic [3:0]         sat_count4;

  always #5 clk = ~clk;

  iir_out_requant dut (
    .clk(clk), .reset(reset), .enb(enb), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_sat(out_sat), .sat_count(sat_count),
    .sat_sticky(sat_sticky), .sat_clr(sat_clr)
  );

  iir_out_requant #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .enb(enb), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready4), .out_data(out_data4), .out_valid(out_valid4),
    .out_ready(out_ready), .out_sat(out_sat4), .sat_count(sat_count4),
    .sat_sticky(sat_sticky4), .sat_clr(sat_clr)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [16:0] q[$];
  longint      m_cnt, m_cnt4;
  logic        m_sticky;
  logic [15:0] last_d;
  logic        last_s;
  bit          last_in_xfer;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Value in output LSBs (2^-14) is x / 2^13, rounded to nearest with ties up,
  // then clamped to the signed 16-bit range. Returns {sat, data}.
  function automatic logic [16:0] ref_q(input longint x);
    longint t, qv;
    t  = x + 4096;
    qv = t / 8192;
    if (t < 0 && (t % 8192) != 0) qv = qv - 1;
    if (qv > 32767)  return {1'b1, 16'h7FFF};
    if (qv < -32768) return {1'b1, 16'h8000};
    return {1'b0, qv[15:0]};
  endfunction

  task automatic tick();
    logic        ix, ox, osat;
    logic [16:0] e;
    #3;
    ix   = enb && in_valid && in_ready;
    ox   = enb && out_valid && out_ready;
    osat = 1'b0;
    if (ox) begin
      if (q.size() == 0) chk("spurious_out", out_valid, 0);
      else begin
        e = q.pop_front();
        chk("out_data", out_data, e[15:0]);
        chk("out_sat", out_sat, e[16]);
        last_d = out_data;
        last_s = out_sat;
        osat   = e[16];
      end
    end
    if (ix) q.push_back(ref_q(in_data));
    if (enb) begin
      if (sat_clr) begin
        m_cnt = 0; m_cnt4 = 0; m_sticky = 1'b0;
      end else if (osat) begin
        m_cnt    = (m_cnt  < 65535) ? m_cnt  + 1 : m_cnt;
        m_cnt4   = (m_cnt4 < 15)    ? m_cnt4 + 1 : m_cnt4;
        m_sticky = 1'b1;
      end
    end
    last_in_xfer = ix;
    @(posedge clk);
    #1;
    chk("sat_count", sat_count, m_cnt);
    chk("sat_sticky", sat_sticky, m_sticky);
    chk("sat_count4", sat_count4, m_cnt4);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) tick();
    chk("drain_timeout", q.size(), 0);
  endtask

  task automatic send(input logic signed [35:0] x);
    last_d       = 16'hDEAD;
    last_s       = 1'bx;
    in_data      = x;
    in_valid     = 1'b1;
    last_in_xfer = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (last_in_xfer) break;
    end
    chk("send_timeout", last_in_xfer, 1);
    in_valid = 1'b0;
  endtask

  initial begin
    int          idx;
    logic [63:0] rr;
    longint      v;
    reset = 1'b1; enb = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sat_clr = 1'b0;
    in_data = '0; m_cnt = 0; m_cnt4 = 0; m_sticky = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_sat_count", sat_count, 0);
    chk("rst_sat_sticky", sat_sticky, 0);
    reset = 1'b0;

    // nominal 1.0 with 2-cycle latency
    in_data = 36'sh008000000; in_valid = 1'b1;
    tick();
    chk("nom_accept", last_in_xfer, 1);
    in_valid = 1'b0;
    chk("lat_c1_valid", out_valid, 0);
    tick();
    chk("lat_c2_valid", out_valid, 1);
    chk("nom_data", out_data, 16'h4000);
    chk("nom_sat", out_sat, 0);
    drain();

    // rounding ties
    send(36'sh000001000);  drain(); chk("tie_pos", last_d, 16'h0001);
    send(-36'sh000001000); drain(); chk("tie_neg", last_d, 16'h0000);
    send(36'sh000000FFF);  drain(); chk("below_half", last_d, 16'h0000);

    // saturation
    send(36'sh018000000);  drain();
    chk("sat_pos", last_d, 16'h7FFF); chk("sat_pos_flag", last_s, 1);
    chk("sat_cnt1", sat_count, 1);    chk("sat_sticky1", sat_sticky, 1);
    send(-36'sh018000000); drain();
    chk("sat_neg", last_d, 16'h8000); chk("sat_cnt2", sat_count, 2);
    send(36'sh00FFFFFFF);  drain();
    chk("sat_round_up", last_d, 16'h7FFF); chk("sat_cnt3", sat_count, 3);

    // backpressure: 8 ramp samples, out_ready low for the first 5 cycles
    out_ready = 1'b0;
    #1;
    idx = 0;
    for (int cyc = 0; cyc < 40 && (idx < 8 || q.size() != 0); cyc++) begin
      if (cyc <= 1) chk("bp_ready_open", in_ready, 1);
      if (cyc >= 2 && cyc <= 4) begin
        chk("bp_ready_full", in_ready, 0);
        chk("bp_hold", out_data, q[0][15:0]);
      end
      out_ready = (cyc >= 5);
      in_valid  = (idx < 8);
      in_data   = 36'(longint'(idx + 1) * 64'sh400000);
      tick();
      if (last_in_xfer) idx++;
    end
    chk("bp_all_in", idx, 8);
    drain();

    // counter clear, then saturation of the 4-bit counter
    sat_clr = 1'b1; tick(); sat_clr = 1'b0;
    chk("clr_cnt", sat_count, 0);
    for (int i = 0; i < 20; i++) send(36'sh018000000);
    drain();
    chk("cnt4_stuck", sat_count4, 15);
    chk("cnt16_20", sat_count, 20);

    // clear in the same cycle as a saturated transfer
    out_ready = 1'b0;
    send(-36'sh018000000);
    for (int i = 0; i < 10 && !out_valid; i++) tick();
    chk("clr_wait_valid", out_valid, 1);
    out_ready = 1'b1; sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    chk("clr_wins_cnt", sat_count, 0);
    chk("clr_wins_sticky", sat_sticky, 0);

    // enb low for 3 cycles mid-stream
    in_valid = 1'b1; in_data = 36'sh008000000; tick();
    in_data = -36'sh008000000; tick();
    in_data = 36'sh004000000;
    enb = 1'b0;
    #1;
    chk("enb_in_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("enb_hold_data", out_data, 16'h4000);
      chk("enb_hold_valid", out_valid, 1);
    end
    enb = 1'b1;
    drain();

    // reset with 2 samples in flight
    send(36'sh018000000); drain();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 36'sh018000000; tick();
    in_data = -36'sh018000000; tick();
    in_valid = 1'b0;
    chk("pre_rst_valid", out_valid, 1);
    reset = 1'b1;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_cnt", sat_count, 0);
    chk("midrst_sticky", sat_sticky, 0);
    q.delete(); m_cnt = 0; m_cnt4 = 0; m_sticky = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0; out_ready = 1'b1;

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      enb       = ($urandom_range(0, 9) != 0);
      in_valid  = $urandom_range(0, 1);
      out_ready = ($urandom_range(0, 3) != 0);
      sat_clr   = ($urandom_range(0, 31) == 0);
      case ($urandom_range(0, 3))
        0: begin rr = {$urandom, $urandom}; v = longint'(signed'(rr[35:0])); end
        1: v = (longint'($urandom_range(0, 2000)) - 1000) * 8192 + 4096 - longint'($urandom_range(0, 1));
        2: begin
             v = 268435456 - 4096 + longint'($urandom_range(0, 8192));
             if ($urandom_range(0, 1) == 1) v = -v;
           end
        default: v = longint'($urandom_range(0, 200000)) - 100000;
      endcase
      in_data = v[35:0];
      tick();
    end
    enb = 1'b1; sat_clr = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
